// File: rtl/ctrl_pipe_pkg.sv
// Shared control-bundle definitions for the decoder and the pipeline control path.
package ctrl_pipe_pkg;

    localparam int CTRL_W = 12;
    localparam int REG_W  = 5;

    // Bit positions inside the 12-bit decoded control bundle
    localparam int B_REG_WRITE  = 11;
    localparam int B_MEM_TO_REG = 10;
    localparam int B_MEM_READ   = 9;
    localparam int B_MEM_WRITE  = 8;
    localparam int B_BRANCH     = 7;
    localparam int B_JUMP       = 6;
    localparam int B_ALU_SRC_HI = 5;
    localparam int B_ALU_SRC_LO = 4;
    localparam int B_ALU_OP_HI  = 3;
    localparam int B_ALU_OP_LO  = 2;
    localparam int B_PC_SRC_HI  = 1;
    localparam int B_PC_SRC_LO  = 0;

    localparam logic [CTRL_W-1:0] CTRL_NOP = '0;

    // EX operand source select
    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    // One pipeline stage: valid bit plus the registered fields
    typedef struct packed {
        logic              valid;
        logic [CTRL_W-1:0] ctrl;
        logic [REG_W-1:0]  rd;
        logic [REG_W-1:0]  rs1;
        logic [REG_W-1:0]  rs2;
    } stage_t;

    localparam stage_t STAGE_EMPTY = '0;

    // Pick the youngest writer of rs; x0 is never forwarded.
    function automatic fwd_sel_e fwd_select(input logic [REG_W-1:0] rs,
                                            input stage_t         mem_s,
                                            input stage_t         wb_s);
        if (mem_s.valid && mem_s.ctrl[B_REG_WRITE] && (mem_s.rd != '0) && (mem_s.rd == rs))
            return FWD_MEM;
        if (wb_s.valid && wb_s.ctrl[B_REG_WRITE] && (wb_s.rd != '0) && (wb_s.rd == rs))
            return FWD_WB;
        return FWD_RF;
    endfunction

endpackage

// File: rtl/ctrl_pipe_hazard.sv
// Combinational hazard unit: load-use detection, redirect qualification, forwarding selects.
module ctrl_hazard
    import ctrl_pipe_pkg::*;
(
    input  stage_t           i_ex,
    input  stage_t           i_mem,
    input  stage_t           i_wb,
    input  logic             i_id_valid,
    input  logic [REG_W-1:0] i_id_rs1,
    input  logic [REG_W-1:0] i_id_rs2,
    input  logic             i_ex_redirect,
    output logic             o_load_use,
    output logic             o_redirect,
    output fwd_sel_e         o_fwd_a,
    output fwd_sel_e         o_fwd_b
);

    logic w_ex_hits_id;
    // Fields of the stage records that no hazard rule looks at; reduced so they are not flagged
    logic w_unused;

    // Hazard and forwarding decisions, all purely combinational
    always_comb begin
        w_ex_hits_id = (i_ex.rd == i_id_rs1) || (i_ex.rd == i_id_rs2);
        o_load_use   = i_ex.valid && i_ex.ctrl[B_MEM_READ] && (i_ex.rd != '0)
                       && i_id_valid && w_ex_hits_id;
        o_redirect   = i_ex_redirect && i_ex.valid;
        o_fwd_a      = fwd_select(i_ex.rs1, i_mem, i_wb);
        o_fwd_b      = fwd_select(i_ex.rs2, i_mem, i_wb);
        w_unused     = ^{i_ex, i_mem, i_wb};
    end

endmodule

// File: rtl/ctrl_pipe.sv
// ID->EX->MEM->WB control pipeline with bubble insertion, flush, global hold and forwarding selects.
module ctrl_pipe
    import ctrl_pipe_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              id_valid,
    input  logic [REG_W-1:0]  id_rd,
    input  logic [REG_W-1:0]  id_rs1,
    input  logic [REG_W-1:0]  id_rs2,
    input  logic              ex_redirect,
    input  logic              hold,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [CTRL_W-1:0] mem_ctrl,
    output logic [CTRL_W-1:0] wb_ctrl,
    output logic [REG_W-1:0]  ex_rd,
    output logic [REG_W-1:0]  mem_rd,
    output logic [REG_W-1:0]  wb_rd,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              stall,
    output logic              flush
);

    stage_t   r_ex, r_mem, r_wb;
    stage_t   w_id, w_ex_next;
    logic     w_load_use, w_redirect;
    fwd_sel_e w_fwd_a, w_fwd_b;

    ctrl_hazard u_hazard (
        .i_ex          (r_ex),
        .i_mem         (r_mem),
        .i_wb          (r_wb),
        .i_id_valid    (id_valid),
        .i_id_rs1      (id_rs1),
        .i_id_rs2      (id_rs2),
        .i_ex_redirect (ex_redirect),
        .o_load_use    (w_load_use),
        .o_redirect    (w_redirect),
        .o_fwd_a       (w_fwd_a),
        .o_fwd_b       (w_fwd_b)
    );

    // Select what enters EX: the ID instruction, or a bubble on redirect/load-use
    always_comb begin
        w_id = STAGE_EMPTY;
        if (id_valid) begin
            w_id.valid = 1'b1;
            w_id.ctrl  = id_ctrl;
            w_id.rd    = id_rd;
            w_id.rs1   = id_rs1;
            w_id.rs2   = id_rs2;
        end
        w_ex_next = w_id;
        if (w_redirect || w_load_use)
            w_ex_next = STAGE_EMPTY;
    end

    // Stage registers: cleared by reset, frozen by hold, otherwise shift one stage per clock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex  <= STAGE_EMPTY;
            r_mem <= STAGE_EMPTY;
            r_wb  <= STAGE_EMPTY;
        end else if (!hold) begin
            r_ex  <= w_ex_next;
            r_mem <= r_ex;
            r_wb  <= r_mem;
        end
    end

    // Output drive: invalid stages show NOP; stall/flush forced low while reset is asserted
    always_comb begin
        ex_ctrl  = r_ex.valid  ? r_ex.ctrl  : CTRL_NOP;
        mem_ctrl = r_mem.valid ? r_mem.ctrl : CTRL_NOP;
        wb_ctrl  = r_wb.valid  ? r_wb.ctrl  : CTRL_NOP;
        ex_rd    = r_ex.rd;
        mem_rd   = r_mem.rd;
        wb_rd    = r_wb.rd;
        fwd_a    = w_fwd_a;
        fwd_b    = w_fwd_b;
        stall    = rst_n && (hold || (w_load_use && !w_redirect));
        flush    = rst_n && !hold && w_redirect;
    end

endmodule

// File: tb/tb_ctrl_pipe.sv
// Self-checking bench for ctrl_pipe: directed scenarios plus randomized run against a stage-list model.
module tb_ctrl_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] id_ctrl = '0;
    logic        id_valid = 1'b0;
    logic [4:0]  id_rd = '0, id_rs1 = '0, id_rs2 = '0;
    logic        ex_redirect = 1'b0;
    logic        hold = 1'b0;
    logic [11:0] ex_ctrl, mem_ctrl, wb_ctrl;
    logic [4:0]  ex_rd, mem_rd, wb_rd;
    logic [1:0]  fwd_a, fwd_b;
    logic        stall, flush;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [11:0] C_LOAD = 12'hE10;  // reg_write|mem_to_reg|mem_read, immediate operand
    localparam logic [11:0] C_ADD  = 12'h800;
    localparam logic [11:0] C_SUB  = 12'h804;

    ctrl_pipe dut (
        .clk(clk), .rst_n(rst_n), .id_ctrl(id_ctrl), .id_valid(id_valid),
        .id_rd(id_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .ex_redirect(ex_redirect), .hold(hold),
        .ex_ctrl(ex_ctrl), .mem_ctrl(mem_ctrl), .wb_ctrl(wb_ctrl),
        .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall(stall), .flush(flush)
    );

    always #5 clk = ~clk;

    // Reference model: list of instructions in flight, index 0 = EX, 1 = MEM, 2 = WB
    typedef struct {
        bit        v;
        bit [11:0] c;
        bit [4:0]  rd, rs1, rs2;
    } instr_t;
    instr_t pipe[3];

    function automatic bit [1:0] model_fwd(input bit [4:0] rs);
        if (pipe[1].v && pipe[1].c[11] && pipe[1].rd != 0 && pipe[1].rd == rs) return 2'b10;
        if (pipe[2].v && pipe[2].c[11] && pipe[2].rd != 0 && pipe[2].rd == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic set_id(input bit v, input bit [11:0] c, input bit [4:0] rd, rs1, rs2);
        id_valid = v; id_ctrl = c; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic drain;
        set_id(0, 12'h0, 0, 0, 0);
        ex_redirect = 0;
        hold = 0;
        repeat (3) next_cycle();
    endtask

    task automatic test_reset;
        logic [56:0] obs;
        rst_n = 0; hold = 1; ex_redirect = 1;
        set_id(1, C_LOAD, 5, 5, 5);
        #3;
        obs = {ex_ctrl, mem_ctrl, wb_ctrl, ex_rd, mem_rd, wb_rd, fwd_a, fwd_b, stall, flush};
        n_vec++;
        if (obs !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h expected 0", obs);
        end
        @(negedge clk);
        hold = 0; ex_redirect = 0;
        set_id(0, 12'h0, 0, 0, 0);
        rst_n = 1;
        next_cycle();
        obs = {ex_ctrl, mem_ctrl, wb_ctrl, ex_rd, mem_rd, wb_rd, fwd_a, fwd_b, stall, flush};
        n_vec++;
        if (obs !== '0) begin
            n_err++;
            $display("FAIL reset_empty_pipe: got %h expected 0", obs);
        end
    endtask

    task automatic test_load_use;
        drain();
        set_id(1, C_LOAD, 5, 1, 2);
        next_cycle();
        set_id(1, C_ADD, 6, 5, 0);
        @(negedge clk);
        n_vec++;
        if ({stall, flush} !== 2'b10) begin
            n_err++;
            $display("FAIL load_use_stall: got stall/flush %b expected 10", {stall, flush});
        end
        next_cycle();
        @(negedge clk);
        n_vec++;
        if ({ex_ctrl, mem_ctrl, stall} !== {12'h000, C_LOAD, 1'b0}) begin
            n_err++;
            $display("FAIL load_use_bubble: got ex %h mem %h stall %b expected ex 000 mem %h stall 0",
                     ex_ctrl, mem_ctrl, stall, C_LOAD);
        end
        next_cycle();
        set_id(0, 12'h0, 0, 0, 0);
        @(negedge clk);
        n_vec++;
        if ({ex_ctrl, wb_ctrl, fwd_a} !== {C_ADD, C_LOAD, 2'b01}) begin
            n_err++;
            $display("FAIL load_use_fwd: got ex %h wb %h fwd_a %b expected %h %h 01",
                     ex_ctrl, wb_ctrl, fwd_a, C_ADD, C_LOAD);
        end
    endtask

    task automatic test_forward;
        // back-to-back: producer in MEM
        drain();
        set_id(1, C_ADD, 3, 1, 2);
        next_cycle();
        set_id(1, C_SUB, 4, 1, 3);
        next_cycle();
        set_id(0, 12'h0, 0, 0, 0);
        @(negedge clk);
        n_vec++;
        if ({fwd_a, fwd_b} !== 4'b0010) begin
            n_err++;
            $display("FAIL fwd_mem: got fwd_a/fwd_b %b expected 0010", {fwd_a, fwd_b});
        end
        // one gap: producer in WB
        drain();
        set_id(1, C_ADD, 3, 1, 2);
        next_cycle();
        set_id(0, 12'h0, 0, 0, 0);
        next_cycle();
        set_id(1, C_SUB, 4, 1, 3);
        next_cycle();
        set_id(0, 12'h0, 0, 0, 0);
        @(negedge clk);
        n_vec++;
        if ({fwd_a, fwd_b} !== 4'b0001) begin
            n_err++;
            $display("FAIL fwd_wb: got fwd_a/fwd_b %b expected 0001", {fwd_a, fwd_b});
        end
        // both MEM and WB write x3: MEM wins
        drain();
        set_id(1, C_ADD, 3, 1, 2);
        next_cycle();
        set_id(1, 12'h801, 3, 1, 2);
        next_cycle();
        set_id(1, C_SUB, 4, 3, 3);
        next_cycle();
        set_id(0, 12'h0, 0, 0, 0);
        @(negedge clk);
        n_vec++;
        if ({fwd_a, fwd_b} !== 4'b1010) begin
            n_err++;
            $display("FAIL fwd_priority: got fwd_a/fwd_b %b expected 1010", {fwd_a, fwd_b});
        end
    endtask

    task automatic test_redirect;
        drain();
        set_id(1, 12'h280, 7, 1, 2);  // branch that also reads memory, to create a load-use
        next_cycle();
        set_id(1, C_ADD, 8, 7, 0);
        ex_redirect = 1;
        @(negedge clk);
        n_vec++;
        if ({stall, flush} !== 2'b01) begin
            n_err++;
            $display("FAIL redirect_wins: got stall/flush %b expected 01", {stall, flush});
        end
        next_cycle();
        ex_redirect = 0;
        set_id(1, 12'h801, 9, 0, 0);
        @(negedge clk);
        n_vec++;
        if ({ex_ctrl, mem_ctrl} !== {12'h000, 12'h280}) begin
            n_err++;
            $display("FAIL redirect_bubble: got ex %h mem %h expected 000 280", ex_ctrl, mem_ctrl);
        end
        // ex_redirect with an empty EX is ignored
        drain();
        set_id(1, C_ADD, 8, 0, 0);
        ex_redirect = 1;
        @(negedge clk);
        n_vec++;
        if (flush !== 1'b0) begin
            n_err++;
            $display("FAIL redirect_ignored: got flush %b expected 0", flush);
        end
        next_cycle();
        ex_redirect = 0;
        set_id(0, 12'h0, 0, 0, 0);
        @(negedge clk);
        n_vec++;
        if (ex_ctrl !== C_ADD) begin
            n_err++;
            $display("FAIL redirect_ignored_ex: got ex %h expected %h", ex_ctrl, C_ADD);
        end
    endtask

    task automatic test_hold;
        logic [11:0] seq[5] = '{12'h801, 12'h802, 12'h803, 12'h804, 12'h805};
        drain();
        for (int k = 0; k < 3; k++) begin
            set_id(1, seq[k], 0, 0, 0);
            next_cycle();
        end
        set_id(1, seq[3], 0, 0, 0);
        hold = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_vec++;
            if ({ex_ctrl, mem_ctrl, wb_ctrl, stall, flush} !== {seq[2], seq[1], seq[0], 2'b10}) begin
                n_err++;
                $display("FAIL hold_cycle%0d: got ex %h mem %h wb %h stall %b flush %b expected %h %h %h 1 0",
                         k, ex_ctrl, mem_ctrl, wb_ctrl, stall, flush, seq[2], seq[1], seq[0]);
            end
            next_cycle();
        end
        hold = 0;
        next_cycle();
        set_id(1, seq[4], 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_vec++;
            if (wb_ctrl !== seq[k+1]) begin
                n_err++;
                $display("FAIL hold_resume%0d: got wb %h expected %h", k, wb_ctrl, seq[k+1]);
            end
            next_cycle();
            set_id(0, 12'h0, 0, 0, 0);
        end
    endtask

    task automatic test_x0;
        drain();
        set_id(1, C_LOAD, 0, 1, 2);
        next_cycle();
        set_id(1, C_ADD, 1, 0, 0);
        @(negedge clk);
        n_vec++;
        if (stall !== 1'b0) begin
            n_err++;
            $display("FAIL x0_no_stall: got stall %b expected 0", stall);
        end
        next_cycle();
        set_id(0, 12'h0, 0, 0, 0);
        @(negedge clk);
        n_vec++;
        if ({ex_ctrl, fwd_a, fwd_b} !== {C_ADD, 4'b0000}) begin
            n_err++;
            $display("FAIL x0_no_fwd: got ex %h fwd %b%b expected %h 0000", ex_ctrl, fwd_a, fwd_b, C_ADD);
        end
    endtask

    task automatic test_async_reset;
        logic [56:0] obs;
        drain();
        for (int k = 1; k <= 3; k++) begin
            set_id(1, C_ADD | 12'(k), 5'(k), 0, 0);
            next_cycle();
        end
        set_id(1, C_ADD, 4, 1, 2);
        hold = 1;
        ex_redirect = 1;
        #2;
        rst_n = 0;
        #1;
        obs = {ex_ctrl, mem_ctrl, wb_ctrl, ex_rd, mem_rd, wb_rd, fwd_a, fwd_b, stall, flush};
        n_vec++;
        if (obs !== '0) begin
            n_err++;
            $display("FAIL async_reset_outputs: got %h expected 0", obs);
        end
        @(negedge clk);
        #1;
        hold = 0;
        ex_redirect = 0;
        set_id(1, 12'h807, 5, 0, 0);
        rst_n = 1;
        next_cycle();
        n_vec++;
        if ({ex_ctrl, wb_ctrl} !== {12'h807, 12'h000}) begin
            n_err++;
            $display("FAIL post_reset_clk1: got ex %h wb %h expected 807 000", ex_ctrl, wb_ctrl);
        end
        set_id(0, 12'h0, 0, 0, 0);
        next_cycle();
        n_vec++;
        if ({mem_ctrl, wb_ctrl} !== {12'h807, 12'h000}) begin
            n_err++;
            $display("FAIL post_reset_clk2: got mem %h wb %h expected 807 000", mem_ctrl, wb_ctrl);
        end
        next_cycle();
        n_vec++;
        if (wb_ctrl !== 12'h807) begin
            n_err++;
            $display("FAIL post_reset_clk3: got wb %h expected 807", wb_ctrl);
        end
    endtask

    task automatic test_random;
        bit          lu, rdr, ex_stall, ex_flush;
        logic [56:0] obs, exp;
        instr_t      nxt;
        drain();
        for (int i = 0; i < 3; i++) pipe[i] = '{0, 0, 0, 0, 0};
        for (int n = 0; n < 400; n++) begin
            set_id($urandom_range(0, 3) != 0, 12'($urandom), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
            hold        = ($urandom_range(0, 4) == 0);
            ex_redirect = ($urandom_range(0, 5) == 0);
            @(negedge clk);
            lu  = pipe[0].v && pipe[0].c[9] && pipe[0].rd != 0 && id_valid
                  && (pipe[0].rd == id_rs1 || pipe[0].rd == id_rs2);
            rdr = ex_redirect && pipe[0].v;
            ex_stall = hold || (lu && !rdr);
            ex_flush = !hold && rdr;
            exp = {pipe[0].c, pipe[1].c, pipe[2].c, pipe[0].rd, pipe[1].rd, pipe[2].rd,
                   model_fwd(pipe[0].rs1), model_fwd(pipe[0].rs2), ex_stall, ex_flush};
            obs = {ex_ctrl, mem_ctrl, wb_ctrl, ex_rd, mem_rd, wb_rd, fwd_a, fwd_b, stall, flush};
            n_vec++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL random_cycle%0d: got %h expected %h", n, obs, exp);
            end
            if (!hold) begin
                nxt = '{0, 0, 0, 0, 0};
                if (id_valid && !rdr && !lu) nxt = '{1, id_ctrl, id_rd, id_rs1, id_rs2};
                pipe[2] = pipe[1];
                pipe[1] = pipe[0];
                pipe[0] = nxt;
            end
            next_cycle();
        end
        hold = 0;
        ex_redirect = 0;
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_forward();
        test_redirect();
        test_hold();
        test_x0();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
